scratch_pad_port: RTL and testbench

Request/response front-end for the scratch-pad single-port synchronous RAM (one-cycle registered read, write-and-read on one address port). Accepts read and write requests over a valid/ready handshake, drives the RAM port directly, and returns read data in order over a second valid/ready handshake. A response buffer with credit-based request throttling absorbs consumer backpressure, so no read datum is ever lost.

---
 rtl/scratch_pad_pkg.sv | 17 +
 rtl/scratch_pad_port_if.sv | 28 ++
 rtl/scratch_pad_rsp_fifo.sv | 46 ++++
 rtl/scratch_pad_port.sv | 60 ++++++
 tb/tb_scratch_pad_port.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scratch_pad_pkg.sv
// Shared definitions for the scratch-pad RAM request/response port.
package scratch_pad_pkg;

  localparam int DEF_WIDTH      = 64;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RSP_DEPTH  = 4;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  function automatic logic is_read(input logic wr);
    return req_kind_e'(wr) == REQ_READ;
  endfunction

endpackage

// File: rtl/scratch_pad_port_if.sv
// Request and response handshake bundle between a client and the scratch-pad port.
interface scratch_pad_port_if
  import scratch_pad_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/scratch_pad_rsp_fifo.sv
// In-order response buffer: registered storage, head visible one cycle after push.
module scratch_pad_rsp_fifo
  import scratch_pad_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_RSP_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/scratch_pad_port.sv
// Valid/ready front-end for the scratch-pad RAM with credit-throttled read responses.
module scratch_pad_port
  import scratch_pad_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scratch_pad_port_if.slave     bus,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_d,
  input  logic [WIDTH-1:0]      ram_q,
  output logic                  busy
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             accept;
  logic             pop;
  logic             inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credits_used;

  assign accept    = bus.req_valid & bus.req_ready;
  assign ram_addr  = bus.req_addr;
  assign ram_d     = bus.req_data;
  assign ram_wr_en = accept & bus.req_wr;

  // Every read holds a buffer slot from accept until its response is popped,
  // so the buffer can never overflow and rsp_ready never feeds req_ready.
  assign credits_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign bus.req_ready = rst_n & (credits_used < (CNT_W + 1)'(RSP_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= accept & is_read(bus.req_wr);
  end

  assign bus.rsp_valid = (fifo_count != '0);
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign busy          = inflight | (fifo_count != '0);

  scratch_pad_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_q),
    .pop       (pop),
    .head      (bus.rsp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_scratch_pad_port.sv
// Self-checking bench for scratch_pad_port: cycle vector table, burst, scoreboard, reset and depth-2 sequences.
module tb_scratch_pad_port;
  import scratch_pad_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scratch_pad_port_if #(.WIDTH(64), .ADDR_WIDTH(8)) bus ();
  scratch_pad_port_if #(.WIDTH(64), .ADDR_WIDTH(8)) bus2 ();

  logic        ram_wr_en, ram2_wr_en;
  logic [7:0]  ram_addr, ram2_addr;
  logic [63:0] ram_d, ram_q, ram2_d, ram2_q;
  logic        busy, busy2;

  scratch_pad_port #(.WIDTH(64), .ADDR_WIDTH(8), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q), .busy(busy));

  scratch_pad_port #(.WIDTH(64), .ADDR_WIDTH(8), .RSP_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .ram_wr_en(ram2_wr_en),
    .ram_addr(ram2_addr), .ram_d(ram2_d), .ram_q(ram2_q), .busy(busy2));

  // Behavioural single-port RAMs; the first can be preloaded with addr*3.
  logic [63:0] ram_mem  [256];
  logic [63:0] ram2_mem [256];
  logic        preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 64'(i * 3);
    end else if (ram_wr_en) begin
      ram_mem[ram_addr] <= ram_d;
    end
    ram_q <= ram_mem[ram_addr];
  end

  always @(posedge clk) begin
    if (ram2_wr_en) ram2_mem[ram2_addr] <= ram2_d;
    ram2_q <= ram2_mem[ram2_addr];
  end

  typedef struct {
    logic        valid;
    logic        wr;
    logic [7:0]  addr;
    logic [63:0] data;
    logic        rdy;
    logic        e_ready;
    logic        e_wr_en;
    logic        e_rvalid;
    logic [63:0] e_rdata;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;

  vec_t        vecs [18];
  exp_t        sb [$];
  logic [63:0] shadow [256];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic vec_t mk(input logic v, input logic w, input logic [7:0] a, input logic [63:0] d,
                              input logic r, input logic er, input logic ewe, input logic erv,
                              input logic [63:0] erd, input logic eb);
    vec_t t;
    t.valid = v; t.wr = w; t.addr = a; t.data = d; t.rdy = r;
    t.e_ready = er; t.e_wr_en = ewe; t.e_rvalid = erv; t.e_rdata = erd; t.e_busy = eb;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [7:0] a,
                               input logic [63:0] d, input logic r);
    bus.req_valid = v;
    bus.req_wr    = w;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.rsp_ready = r;
  endtask

  task automatic applyStimulus2(input logic v, input logic w, input logic [7:0] a,
                                input logic [63:0] d, input logic r);
    bus2.req_valid = v;
    bus2.req_wr    = w;
    bus2.req_addr  = a;
    bus2.req_data  = d;
    bus2.rsp_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scoreboard slot: checks credit, valid and head data, then updates the model.
  task automatic sbSlot(input logic v, input logic w, input logic [7:0] a,
                        input logic [63:0] d, input logic r);
    logic exp_ready, exp_valid;
    exp_ready = (sb.size() < 4);
    exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
    checkOutput($sformatf("rand%0d req_ready", cyc), 64'(bus.req_ready), 64'(exp_ready));
    checkOutput($sformatf("rand%0d rsp_valid", cyc), 64'(bus.rsp_valid), 64'(exp_valid));
    if (exp_valid) begin
      checkOutput($sformatf("rand%0d rsp_data", cyc), bus.rsp_data, sb[0].d);
      if (r) void'(sb.pop_front());
    end
    if (v && exp_ready) begin
      if (w) shadow[a] = d;
      else   sb.push_back('{d: shadow[a], due: cyc + 2});
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk(1'b1, 1'b1, 8'd5, 64'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 8'd5, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    vecs[3]  = mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF, 1'b1);
    vecs[4]  = mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 8'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 8'd1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 8'd2, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 1'b1);
    vecs[8]  = mk(1'b1, 1'b0, 8'd3, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 8'd4, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1);
    vecs[10] = mk(1'b1, 1'b0, 8'd4, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1);
    vecs[11] = mk(1'b1, 1'b0, 8'd4, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1);
    vecs[12] = mk(1'b1, 1'b0, 8'd4, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 64'd3, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd3, 1'b1);
    vecs[14] = mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'd6, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'd9, 1'b1);
    vecs[16] = mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'd12, 1'b1);
    vecs[17] = mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'd5, 64'd0, 1'b1);
    applyStimulus2(1'b0, 1'b0, 8'd0, 64'd0, 1'b0);
    preload = 1'b1;
    step();
    step();
    preload = 1'b0;
    @(negedge clk);
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset ram_wr_en", 64'(ram_wr_en), 64'd0);
    checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset req_ready2", 64'(bus2.req_ready), 64'd0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rdy);
      @(negedge clk);
      checkOutput($sformatf("vec%0d req_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_ready));
      checkOutput($sformatf("vec%0d ram_wr_en", i), 64'(ram_wr_en), 64'(vecs[i].e_wr_en));
      checkOutput($sformatf("vec%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].e_rvalid));
      checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
      if (vecs[i].e_rvalid)
        checkOutput($sformatf("vec%0d rsp_data", i), bus.rsp_data, vecs[i].e_rdata);
      step();
    end

    // Back-to-back reads with the consumer always ready: one response per cycle.
    applyStimulus(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
    preload = 1'b1;
    step();
    preload = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) applyStimulus(1'b1, 1'b0, 8'(c), 64'd0, 1'b1);
      else        applyStimulus(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
      @(negedge clk);
      if (c < 16) checkOutput($sformatf("burst%0d req_ready", c), 64'(bus.req_ready), 64'd1);
      checkOutput($sformatf("burst%0d rsp_valid", c), 64'(bus.rsp_valid), 64'(c >= 2));
      if (c >= 2) checkOutput($sformatf("burst%0d rsp_data", c), bus.rsp_data, 64'((c - 2) * 3));
      step();
    end
    @(negedge clk);
    checkOutput("burst idle busy", 64'(busy), 64'd0);
    step();

    // Mixed traffic with random backpressure against the scoreboard.
    applyStimulus(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
    preload = 1'b1;
    step();
    preload = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = 64'(i * 3);
    for (int n = 0; n < 1000; n++) begin
      logic v, w, r;
      logic [7:0] a;
      logic [63:0] d;
      v = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 2) == 0);
      a = 8'($urandom_range(0, 15));
      d = {$urandom, $urandom};
      r = 1'($urandom_range(0, 1));
      applyStimulus(v, w, a, d, r);
      @(negedge clk);
      sbSlot(v, w, a, d, r);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
      @(negedge clk);
      sbSlot(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
      step();
    end
    @(negedge clk);
    checkOutput("drain busy", 64'(busy), 64'd0);
    step();

    // Reset with three responses buffered and one read in flight.
    applyStimulus(1'b0, 1'b0, 8'd0, 64'd0, 1'b0);
    preload = 1'b1;
    step();
    preload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 64'd0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 8'd0, 64'd0, 1'b0);
    @(negedge clk);
    checkOutput("full busy", 64'(busy), 64'd1);
    checkOutput("full req_ready", 64'(bus.req_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'd3, 64'h77, 1'b0);
    #1;
    checkOutput("midrst req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("midrst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("midrst busy", 64'(busy), 64'd0);
    checkOutput("midrst ram_wr_en", 64'(ram_wr_en), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd7, 64'd0, 1'b1);
    @(negedge clk);
    checkOutput("release req_ready", 64'(bus.req_ready), 64'd1);
    step();
    applyStimulus(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
    @(negedge clk);
    checkOutput("post rsp_valid T+1", 64'(bus.rsp_valid), 64'd0);
    checkOutput("post busy T+1", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    checkOutput("post rsp_valid T+2", 64'(bus.rsp_valid), 64'd1);
    checkOutput("post rsp_data T+2", bus.rsp_data, 64'd21);
    step();
    @(negedge clk);
    checkOutput("post rsp_valid T+3", 64'(bus.rsp_valid), 64'd0);
    checkOutput("post busy T+3", 64'(busy), 64'd0);
    step();

    // Depth-2 instance: write then three reads with the consumer stalled.
    applyStimulus2(1'b1, 1'b1, 8'd9, 64'h55, 1'b0);
    @(negedge clk);
    checkOutput("d2 wr req_ready", 64'(bus2.req_ready), 64'd1);
    checkOutput("d2 wr ram_wr_en", 64'(ram2_wr_en), 64'd1);
    step();
    applyStimulus2(1'b1, 1'b0, 8'd9, 64'd0, 1'b0);
    @(negedge clk);
    checkOutput("d2 rd1 req_ready", 64'(bus2.req_ready), 64'd1);
    checkOutput("d2 rd1 ram_wr_en", 64'(ram2_wr_en), 64'd0);
    checkOutput("d2 rd1 busy", 64'(busy2), 64'd0);
    step();
    @(negedge clk);
    checkOutput("d2 rd2 req_ready", 64'(bus2.req_ready), 64'd1);
    step();
    @(negedge clk);
    checkOutput("d2 rd3 req_ready", 64'(bus2.req_ready), 64'd0);
    checkOutput("d2 rd3 rsp_valid", 64'(bus2.rsp_valid), 64'd1);
    checkOutput("d2 rd3 rsp_data", bus2.rsp_data, 64'h55);
    step();
    @(negedge clk);
    checkOutput("d2 stall req_ready", 64'(bus2.req_ready), 64'd0);
    checkOutput("d2 stall rsp_data", bus2.rsp_data, 64'h55);
    step();
    applyStimulus2(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
    @(negedge clk);
    checkOutput("d2 pop1 rsp_valid", 64'(bus2.rsp_valid), 64'd1);
    checkOutput("d2 pop1 req_ready", 64'(bus2.req_ready), 64'd0);
    step();
    @(negedge clk);
    checkOutput("d2 pop2 rsp_valid", 64'(bus2.rsp_valid), 64'd1);
    checkOutput("d2 pop2 rsp_data", bus2.rsp_data, 64'h55);
    checkOutput("d2 pop2 req_ready", 64'(bus2.req_ready), 64'd1);
    step();
    @(negedge clk);
    checkOutput("d2 end rsp_valid", 64'(bus2.rsp_valid), 64'd0);
    checkOutput("d2 end busy", 64'(busy2), 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
